dp_dmi_master: RTL and testbench

DMI initiator for the debug transport side of the JTAG debug path. It turns JTAG `dmi` register updates (41-bit `{address, data, op}`) into read/write transactions toward the debug module, and collects each response. It holds the sticky DMI status and provides the value loaded into the `dmi` shift register at capture-DR. It sits between the TAP/DTM register logic and the debug module's DMI port.

---
 rtl/dp_dmi_master_if.sv | 26 ++
 rtl/dp_dmi_master.sv | 124 ++++++++++++
 tb/tb_dp_dmi_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dp_dmi_master_if.sv
// DMI request/response channel between the DTM-side initiator and the debug module.
// Request is valid/ready; response is valid/ready, with the initiator owning resp_ready.
interface dp_dmi_master_if #(
    parameter int ABITS = 7,
    parameter int DBITS = 32
);
    logic             dmi_req_valid;
    logic             dmi_req_ready;
    logic [ABITS-1:0] dmi_address;
    logic [DBITS-1:0] dmi_wdata;
    logic [1:0]       dmi_op;
    logic             dmi_resp_valid;
    logic             dmi_resp_ready;
    logic [DBITS-1:0] dmi_rdata;
    logic [1:0]       dmi_resp_op;

    modport master (
        output dmi_req_valid, dmi_address, dmi_wdata, dmi_op, dmi_resp_ready,
        input  dmi_req_ready, dmi_resp_valid, dmi_rdata, dmi_resp_op
    );

    modport slave (
        input  dmi_req_valid, dmi_address, dmi_wdata, dmi_op, dmi_resp_ready,
        output dmi_req_ready, dmi_resp_valid, dmi_rdata, dmi_resp_op
    );
endinterface

// File: rtl/dp_dmi_master.sv
// DMI initiator: turns dmi update-DR into one DM transaction, keeps sticky status and capture value.
// Request one cycle after update; holds request under backpressure; responses always drained outside REQ.
module dp_dmi_master #(
    parameter int ABITS = 7,
    parameter int DBITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   upd_dmi,
    input  logic [ABITS+DBITS+1:0] upd_data,
    input  logic                   cap_dmi,
    output logic [ABITS+DBITS+1:0] cap_data,
    input  logic                   dmireset,
    input  logic                   dmihardreset,
    output logic [1:0]             dmistat,
    output logic                   busy,
    dp_dmi_master_if.master        dmi
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             stat_q, stat_d, stat_base;
    logic [ABITS-1:0]       addr_q, addr_d;
    logic [DBITS-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]             op_q, op_d;
    logic [ABITS+DBITS+1:0] cap_q, cap_d;
    logic                   req_valid_q, req_valid_d;
    logic                   err2, err3;
    logic [1:0]             upd_op;

    assign upd_op = upd_data[1:0];
    // Status clears are applied before the update is judged, so clear+update can start a transaction.
    assign stat_base = (dmireset || dmihardreset) ? 2'd0 : stat_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        cap_d   = cap_q;
        err2    = 1'b0;
        err3    = 1'b0;
        if (cap_dmi) begin
            cap_d = {addr_q, rdata_q, (state_q != S_IDLE) ? 2'd3 : stat_q};
        end
        case (state_q)
            S_IDLE: begin
                if (upd_dmi && stat_base == 2'd0) begin
                    if (upd_op == 2'd1 || upd_op == 2'd2) begin
                        addr_d  = upd_data[ABITS+DBITS+1 -: ABITS];
                        wdata_d = upd_data[DBITS+1:2];
                        op_d    = upd_op;
                        state_d = S_REQ;
                    end else if (upd_op == 2'd3) begin
                        err2 = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (dmi.dmi_req_ready) state_d = S_RESP;
                if (upd_dmi || cap_dmi) err3 = 1'b1;
            end
            S_RESP: begin
                if (dmi.dmi_resp_valid) begin
                    rdata_d = dmi.dmi_rdata;
                    state_d = S_IDLE;
                    if (dmi.dmi_resp_op == 2'd2) err2 = 1'b1;
                    if (dmi.dmi_resp_op == 2'd3) err3 = 1'b1;
                end
                if (upd_dmi || cap_dmi) err3 = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Hard reset aborts everything in flight but leaves the last captured/returned data intact.
        if (dmihardreset) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            op_d    = op_q;
            rdata_d = rdata_q;
            cap_d   = cap_q;
            err2    = 1'b0;
            err3    = 1'b0;
        end
        stat_d = stat_base;
        if (stat_base == 2'd0) begin
            if (err3)      stat_d = 2'd3;
            else if (err2) stat_d = 2'd2;
        end
        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stat_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= 2'd0;
            rdata_q     <= '0;
            cap_q       <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            rdata_q     <= rdata_d;
            cap_q       <= cap_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign dmistat            = stat_q;
    assign cap_data           = cap_q;
    assign dmi.dmi_req_valid  = req_valid_q;
    assign dmi.dmi_address    = addr_q;
    assign dmi.dmi_wdata      = wdata_q;
    assign dmi.dmi_op         = op_q;
    assign dmi.dmi_resp_ready = (state_q != S_REQ);
endmodule

// File: tb/tb_dp_dmi_master.sv
// Directed self-checking bench for dp_dmi_master; inputs driven and outputs sampled 1ns after rising edge.
module tb_dp_dmi_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        upd_dmi, cap_dmi, dmireset, dmihardreset;
    logic [40:0] upd_data;
    logic [40:0] cap_data;
    logic [1:0]  dmistat;
    logic        busy;
    int          total = 0;
    int          bad = 0;
    int          req_cnt = 0;

    dp_dmi_master_if #(.ABITS(7), .DBITS(32)) bus();

    dp_dmi_master #(.ABITS(7), .DBITS(32)) dut (
        .clk(clk), .rst(rst), .upd_dmi(upd_dmi), .upd_data(upd_data),
        .cap_dmi(cap_dmi), .cap_data(cap_data), .dmireset(dmireset),
        .dmihardreset(dmihardreset), .dmistat(dmistat), .busy(busy), .dmi(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.dmi_req_valid && bus.dmi_req_ready) req_cnt <= req_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        upd_dmi = 0; cap_dmi = 0; dmireset = 0; dmihardreset = 0;
        bus.dmi_resp_valid = 0; bus.dmi_resp_op = 2'd0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (dmistat !== 2'd0) begin bad++; $display("FAIL rst_stat got=%0d exp=0", dmistat); end
        total++; if (bus.dmi_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.dmi_req_valid); end
        total++; if (bus.dmi_resp_ready !== 1'b1) begin bad++; $display("FAIL rst_rready got=%b exp=1", bus.dmi_resp_ready); end
        total++; if ({bus.dmi_address, bus.dmi_wdata, bus.dmi_op} !== 41'd0) begin bad++; $display("FAIL rst_req got=%h exp=0", {bus.dmi_address, bus.dmi_wdata, bus.dmi_op}); end
        total++; if (cap_data !== 41'd0) begin bad++; $display("FAIL rst_cap got=%h exp=0", cap_data); end
    endtask

    task automatic test_read();
        bus.dmi_req_ready = 1; upd_dmi = 1; upd_data = {7'h11, 32'h0, 2'd1};
        step(); upd_dmi = 0;
        total++; if (bus.dmi_req_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rd_req got=%b%b exp=11", bus.dmi_req_valid, busy); end
        total++; if (bus.dmi_address !== 7'h11 || bus.dmi_op !== 2'd1) begin bad++; $display("FAIL rd_addr got=%h/%0d exp=11/1", bus.dmi_address, bus.dmi_op); end
        total++; if (bus.dmi_resp_ready !== 1'b0) begin bad++; $display("FAIL rd_rready_req got=%b exp=0", bus.dmi_resp_ready); end
        step();
        total++; if (busy !== 1'b1 || bus.dmi_req_valid !== 1'b0 || bus.dmi_resp_ready !== 1'b1) begin bad++; $display("FAIL rd_resp_state got=%b%b%b exp=101", busy, bus.dmi_req_valid, bus.dmi_resp_ready); end
        bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'hDEADBEEF; bus.dmi_resp_op = 2'd0;
        step(); clear_in();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_done got=%b exp=0", busy); end
        cap_dmi = 1; step(); cap_dmi = 0;
        total++; if (cap_data !== {7'h11, 32'hDEADBEEF, 2'd0}) begin bad++; $display("FAIL rd_cap got=%h exp=%h", cap_data, {7'h11, 32'hDEADBEEF, 2'd0}); end
    endtask

    task automatic test_write_bp();
        bus.dmi_req_ready = 0; upd_dmi = 1; upd_data = {7'h10, 32'h80000001, 2'd2};
        step(); upd_dmi = 0;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.dmi_req_valid !== 1'b1 || bus.dmi_wdata !== 32'h80000001 || bus.dmi_op !== 2'd2 || bus.dmi_resp_ready !== 1'b0) begin bad++; $display("FAIL wr_hold[%0d] got=%b %h %0d %b exp=1 80000001 2 0", i, bus.dmi_req_valid, bus.dmi_wdata, bus.dmi_op, bus.dmi_resp_ready); end
            step();
        end
        bus.dmi_req_ready = 1; step(); bus.dmi_req_ready = 0;
        total++; if (bus.dmi_req_valid !== 1'b0 || bus.dmi_resp_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL wr_resp got=%b%b%b exp=011", bus.dmi_req_valid, bus.dmi_resp_ready, busy); end
        bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'h0; step(); clear_in();
        total++; if (dmistat !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL wr_done got=%0d/%b exp=0/0", dmistat, busy); end
    endtask

    task automatic test_collision();
        int c0;
        c0 = req_cnt;
        bus.dmi_req_ready = 1; upd_dmi = 1; upd_data = {7'h05, 32'h0, 2'd1};
        step(); upd_dmi = 0; step();
        upd_dmi = 1; upd_data = {7'h06, 32'h0, 2'd1}; step(); upd_dmi = 0;
        total++; if (dmistat !== 2'd3 || busy !== 1'b1 || bus.dmi_address !== 7'h05) begin bad++; $display("FAIL col_stat got=%0d/%b/%h exp=3/1/05", dmistat, busy, bus.dmi_address); end
        bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'h11; step(); clear_in();
        total++; if (req_cnt - c0 !== 1) begin bad++; $display("FAIL col_count got=%0d exp=1", req_cnt - c0); end
        upd_dmi = 1; upd_data = {7'h07, 32'h0, 2'd1}; step(); upd_dmi = 0;
        total++; if (busy !== 1'b0 || bus.dmi_address !== 7'h05 || dmistat !== 2'd3) begin bad++; $display("FAIL col_ignore got=%b/%h/%0d exp=0/05/3", busy, bus.dmi_address, dmistat); end
        dmireset = 1; upd_dmi = 1; upd_data = {7'h08, 32'h0, 2'd1}; step(); clear_in();
        total++; if (busy !== 1'b1 || bus.dmi_address !== 7'h08 || dmistat !== 2'd0) begin bad++; $display("FAIL col_restart got=%b/%h/%0d exp=1/08/0", busy, bus.dmi_address, dmistat); end
        step(); bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'h22; step(); clear_in();
        total++; if (busy !== 1'b0 || dmistat !== 2'd0) begin bad++; $display("FAIL col_done got=%b/%0d exp=0/0", busy, dmistat); end
    endtask

    task automatic test_failed();
        bus.dmi_req_ready = 1; upd_dmi = 1; upd_data = {7'h09, 32'h0, 2'd1};
        step(); upd_dmi = 0; step();
        bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'h1234; bus.dmi_resp_op = 2'd2; step(); clear_in();
        total++; if (dmistat !== 2'd2 || busy !== 1'b0) begin bad++; $display("FAIL fl_stat got=%0d/%b exp=2/0", dmistat, busy); end
        cap_dmi = 1; step(); cap_dmi = 0;
        total++; if (cap_data !== {7'h09, 32'h1234, 2'd2}) begin bad++; $display("FAIL fl_cap_idle got=%h exp=%h", cap_data, {7'h09, 32'h1234, 2'd2}); end
        bus.dmi_req_ready = 0; dmireset = 1; upd_dmi = 1; upd_data = {7'h0C, 32'h0, 2'd1}; step(); clear_in();
        cap_dmi = 1; step(); cap_dmi = 0;
        total++; if (cap_data !== {7'h0C, 32'h1234, 2'd3} || dmistat !== 2'd3) begin bad++; $display("FAIL fl_cap_busy got=%h/%0d exp=%h/3", cap_data, dmistat, {7'h0C, 32'h1234, 2'd3}); end
        bus.dmi_req_ready = 1; step(); bus.dmi_req_ready = 0;
        bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'h5678; bus.dmi_resp_op = 2'd2; step(); clear_in();
        total++; if (dmistat !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL fl_sticky got=%0d/%b exp=3/0", dmistat, busy); end
    endtask

    task automatic test_hardreset();
        dmireset = 1; step(); dmireset = 0;
        total++; if (dmistat !== 2'd0) begin bad++; $display("FAIL hr_clr got=%0d exp=0", dmistat); end
        bus.dmi_req_ready = 1; upd_dmi = 1; upd_data = {7'h0A, 32'h0, 2'd1}; step(); upd_dmi = 0; step();
        dmihardreset = 1; step(); dmihardreset = 0;
        total++; if (busy !== 1'b0 || dmistat !== 2'd0 || bus.dmi_req_valid !== 1'b0) begin bad++; $display("FAIL hr_idle got=%b/%0d/%b exp=0/0/0", busy, dmistat, bus.dmi_req_valid); end
        bus.dmi_resp_valid = 1; bus.dmi_rdata = 32'h00000BAD;
        total++; if (bus.dmi_resp_ready !== 1'b1) begin bad++; $display("FAIL hr_drain got=%b exp=1", bus.dmi_resp_ready); end
        step(); clear_in();
        cap_dmi = 1; step(); cap_dmi = 0;
        total++; if (cap_data !== {7'h0A, 32'h5678, 2'd0} || busy !== 1'b0) begin bad++; $display("FAIL hr_rdata got=%h/%b exp=%h/0", cap_data, busy, {7'h0A, 32'h5678, 2'd0}); end
    endtask

    task automatic test_reserved_and_rst();
        int c0;
        c0 = req_cnt;
        bus.dmi_req_ready = 1; upd_dmi = 1; upd_data = {7'h03, 32'hFFFF0000, 2'd3}; step(); upd_dmi = 0; step();
        total++; if (dmistat !== 2'd2 || busy !== 1'b0 || req_cnt != c0 || bus.dmi_address !== 7'h0A) begin bad++; $display("FAIL rsv got=%0d/%b/%0d/%h exp=2/0/0/0a", dmistat, busy, req_cnt - c0, bus.dmi_address); end
        dmireset = 1; bus.dmi_req_ready = 0; upd_dmi = 1; upd_data = {7'h15, 32'hCAFEF00D, 2'd2}; step(); clear_in();
        total++; if (bus.dmi_req_valid !== 1'b1 || bus.dmi_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/cafef00d", bus.dmi_req_valid, bus.dmi_wdata); end
        rst = 1; step(); rst = 0;
        test_reset();
    endtask

    initial begin
        rst = 1; clear_in(); upd_data = '0; bus.dmi_req_ready = 0; bus.dmi_rdata = '0;
        step(); step(); rst = 0;
        test_reset();
        test_read();
        test_write_bp();
        test_collision();
        test_failed();
        test_hardreset();
        test_reserved_and_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
